// File: rtl/data_mem_pkg.sv
// data_mem_pkg: shared state encoding and index-width helper for data_mem_ctrl
package data_mem_pkg;
  typedef enum logic [0:0] {CLEAR = 1'b0, IDLE = 1'b1} state_e;
  localparam logic [0:0] ST_CLEAR = CLEAR;
  localparam logic [0:0] ST_IDLE  = IDLE;
  function automatic int idx_w(input int depth);
    return depth > 1 ? $clog2(depth) : 1;
  endfunction
endpackage

// File: rtl/data_mem_if.sv
// data_mem_if: valid/ready request and response channels of the data memory
interface data_mem_if #(parameter int DATA_W = 8, parameter int ADDR_W = 8);
  logic              req_valid;
  logic              req_ready;
  logic              req_we;
  logic [ADDR_W-1:0] req_addr;
  logic [DATA_W-1:0] req_wdata;
  logic              rsp_valid;
  logic              rsp_ready;
  logic              rsp_we;
  logic [DATA_W-1:0] rsp_rdata;
  logic              rsp_err;
  modport master (
    output req_valid, req_we, req_addr, req_wdata, rsp_ready,
    input  req_ready, rsp_valid, rsp_we, rsp_rdata, rsp_err
  );
  modport slave (
    input  req_valid, req_we, req_addr, req_wdata, rsp_ready,
    output req_ready, rsp_valid, rsp_we, rsp_rdata, rsp_err
  );
endinterface

// File: rtl/data_mem_array.sv
// data_mem_array: DATA_W x DEPTH storage, synchronous write, asynchronous read, no reset
module data_mem_array
  import data_mem_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 16,
  parameter int IW     = idx_w(DEPTH)
) (
  input  logic              clk,
  input  logic              we_i,
  input  logic [IW-1:0]     waddr_i,
  input  logic [DATA_W-1:0] wdata_i,
  input  logic [IW-1:0]     raddr_i,
  output logic [DATA_W-1:0] rdata_o
);
  logic [DATA_W-1:0] mem [DEPTH];
  always_ff @(posedge clk)
    if (we_i) mem[waddr_i] <= wdata_i;
  assign rdata_o = mem[raddr_i];
endmodule

// File: rtl/data_mem_ctrl.sv
// data_mem_ctrl: handshaked data memory with range check, registered response and clear sweep
module data_mem_ctrl
  import data_mem_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 8,
  parameter int DEPTH  = 16
) (
  input  logic       clk,
  input  logic       rst_n,
  data_mem_if.slave  bus,
  input  logic       clear,
  output logic       busy
);
  localparam int IW = idx_w(DEPTH);
  localparam logic [IW-1:0] LAST = IW'(DEPTH - 1);

  if (DEPTH < 2 || DEPTH > (1 << ADDR_W)) begin : g_bad_depth
    $error("data_mem_ctrl: DEPTH out of range for ADDR_W");
  end

  logic [0:0]        state_q, state_d;
  logic [IW-1:0]     ptr_q, ptr_d;
  logic              rsp_valid_q, rsp_valid_d;
  logic              rsp_we_q, rsp_we_d;
  logic              rsp_err_q, rsp_err_d;
  logic [DATA_W-1:0] rsp_rdata_q, rsp_rdata_d;
  logic              accept, in_range, hold, mem_we;
  logic [IW-1:0]     idx, waddr;
  logic [DATA_W-1:0] wdata, rd;

  assign busy          = state_q == ST_CLEAR;
  assign in_range      = {1'b0, bus.req_addr} < (ADDR_W + 1)'(DEPTH);
  assign idx           = bus.req_addr[IW-1:0];
  assign bus.req_ready = state_q == ST_IDLE && (!rsp_valid_q || bus.rsp_ready);
  assign accept        = bus.req_valid && bus.req_ready;
  assign hold          = rsp_valid_q && !bus.rsp_ready;

  // the sweep owns the write port while busy; requests cannot be accepted then
  always_comb begin
    mem_we      = busy || (accept && bus.req_we && in_range);
    waddr       = busy ? ptr_q : idx;
    wdata       = busy ? '0 : bus.req_wdata;
    state_d     = busy ? (ptr_q == LAST ? ST_IDLE : ST_CLEAR) : (clear ? ST_CLEAR : ST_IDLE);
    ptr_d       = busy && ptr_q != LAST ? ptr_q + 1'b1 : '0;
    rsp_valid_d = accept || hold;
    rsp_we_d    = accept ? bus.req_we : hold && rsp_we_q;
    rsp_err_d   = accept ? !in_range : hold && rsp_err_q;
    rsp_rdata_d = accept ? (!bus.req_we && in_range ? rd : '0) : hold ? rsp_rdata_q : '0;
  end

  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state_q     <= ST_CLEAR;
      ptr_q       <= '0;
      rsp_valid_q <= 1'b0;
      rsp_we_q    <= 1'b0;
      rsp_err_q   <= 1'b0;
      rsp_rdata_q <= '0;
    end else begin
      state_q     <= state_d;
      ptr_q       <= ptr_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_we_q    <= rsp_we_d;
      rsp_err_q   <= rsp_err_d;
      rsp_rdata_q <= rsp_rdata_d;
    end

  data_mem_array #(.DATA_W(DATA_W), .DEPTH(DEPTH), .IW(IW)) u_array (
    .clk     (clk),
    .we_i    (mem_we),
    .waddr_i (waddr),
    .wdata_i (wdata),
    .raddr_i (idx),
    .rdata_o (rd)
  );

  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_we    = rsp_we_q;
  assign bus.rsp_err   = rsp_err_q;
  assign bus.rsp_rdata = rsp_rdata_q;
endmodule

// File: tb/tb_data_mem_ctrl.sv
// tb_data_mem_ctrl: scoreboard bench for data_mem_ctrl with a reference memory model
module tb_data_mem_ctrl;
  typedef struct {
    logic [9:0] v;
    int         cyc;
  } rsp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  logic clear = 1'b0;
  logic busy;
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  logic [7:0] mem_m [16];
  rsp_t exp_q [$];
  rsp_t got_q [$];

  data_mem_if #(.DATA_W(8), .ADDR_W(8)) bus ();

  data_mem_ctrl #(.DATA_W(8), .ADDR_W(8), .DEPTH(16)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus),
    .clear (clear),
    .busy  (busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk)
    if (rst_n && bus.rsp_valid && bus.rsp_ready)
      got_q.push_back('{v: {bus.rsp_we, bus.rsp_err, bus.rsp_rdata}, cyc: cyc});

  task automatic zero_model();
    for (int i = 0; i < 16; i++) mem_m[i] = 8'h00;
  endtask

  task automatic send(input logic we, input logic [7:0] addr, input logic [7:0] wd);
    rsp_t e;
    logic in_r;
    in_r = addr < 8'd16;
    bus.req_valid = 1'b1;
    bus.req_we    = we;
    bus.req_addr  = addr;
    bus.req_wdata = wd;
    @(negedge clk);
    for (int t = 0; t < 30 && !bus.req_ready; t++) @(negedge clk);
    e.cyc = cyc;
    e.v   = {we, !in_r, (!we && in_r) ? mem_m[addr[3:0]] : 8'h00};
    if (we && in_r) mem_m[addr[3:0]] = wd;
    exp_q.push_back(e);
    @(posedge clk);
    #1;
    bus.req_valid = 1'b0;
  endtask

  task automatic wait_rsp();
    for (int t = 0; t < 60 && got_q.size() < exp_q.size(); t++) @(negedge clk);
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rsp_t e, g;
    #2 rst_n = 1'b0;
    #10;
    checks++;
    if ({busy, bus.req_ready, bus.rsp_valid, bus.rsp_we, bus.rsp_err, bus.rsp_rdata} !== 13'b1_0000_0000_0000) begin
      errors++;
      $display("FAIL reset_outputs: got %b required %b",
               {busy, bus.req_ready, bus.rsp_valid, bus.rsp_we, bus.rsp_err, bus.rsp_rdata}, 13'b1_0000_0000_0000);
    end
    zero_model();
    @(posedge clk);
    #1 rst_n = 1'b1;
    for (int i = 1; i <= 16; i++) begin
      @(posedge clk);
      #1;
      checks++;
      if ({busy, bus.req_ready, bus.rsp_valid} !== {i < 16, i == 16, 1'b0}) begin
        errors++;
        $display("FAIL reset_sweep edge %0d: got busy/ready/valid %b required %b",
                 i, {busy, bus.req_ready, bus.rsp_valid}, {i < 16, i == 16, 1'b0});
      end
    end
    for (int i = 0; i < 16; i++) send(1'b0, 8'(i), 8'h00);
    wait_rsp();
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      checks++;
      if (got_q.size() == 0) begin
        errors++;
        $display("FAIL reset_readback: no response, required %h", e.v);
      end else begin
        g = got_q.pop_front();
        if (g.v !== e.v) begin
          errors++;
          $display("FAIL reset_readback: got %h required %h", g.v, e.v);
        end
      end
    end
  endtask

  task automatic test_write_read();
    rsp_t e, g;
    send(1'b1, 8'd3, 8'hA5);
    send(1'b0, 8'd3, 8'h00);
    wait_rsp();
    for (int k = 0; k < 2; k++) begin
      e = exp_q.pop_front();
      checks++;
      if (got_q.size() == 0) begin
        errors++;
        $display("FAIL write_read %0d: no response, required %h", k, e.v);
      end else begin
        g = got_q.pop_front();
        if (g.v !== (k == 0 ? 10'h200 : 10'h0A5)) begin
          errors++;
          $display("FAIL write_read %0d: got %h required %h", k, g.v, k == 0 ? 10'h200 : 10'h0A5);
        end
        if (k == 1) begin
          checks++;
          if (g.cyc - e.cyc !== 1) begin
            errors++;
            $display("FAIL read_latency: got %0d cycles required 1", g.cyc - e.cyc);
          end
        end
      end
    end
  endtask

  task automatic test_range();
    rsp_t e, g;
    send(1'b0, 8'd16, 8'h00);
    send(1'b0, 8'hFF, 8'h00);
    send(1'b1, 8'd20, 8'h99);
    send(1'b0, 8'd0, 8'h00);
    send(1'b0, 8'd4, 8'h00);
    send(1'b0, 8'd3, 8'h00);
    wait_rsp();
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      checks++;
      if (got_q.size() == 0) begin
        errors++;
        $display("FAIL range: no response, required %h", e.v);
      end else begin
        g = got_q.pop_front();
        if (g.v !== e.v) begin
          errors++;
          $display("FAIL range: got %h required %h", g.v, e.v);
        end
      end
    end
  endtask

  task automatic test_backpressure();
    rsp_t e, g, g0;
    send(1'b1, 8'd7, 8'h3C);
    wait_rsp();
    e = exp_q.pop_front();
    checks++;
    if (got_q.size() == 0 || got_q[0].v !== e.v) begin
      errors++;
      $display("FAIL bp_write: got %0d responses required %h", got_q.size(), e.v);
    end
    if (got_q.size() > 0) g = got_q.pop_front();
    bus.rsp_ready = 1'b0;
    send(1'b0, 8'd7, 8'h00);
    bus.req_valid = 1'b1;
    bus.req_we    = 1'b0;
    bus.req_addr  = 8'd3;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checks++;
      if ({bus.rsp_valid, bus.rsp_rdata, bus.req_ready} !== {1'b1, 8'h3C, 1'b0}) begin
        errors++;
        $display("FAIL bp_hold %0d: got valid/rdata/ready %b required %b",
                 i, {bus.rsp_valid, bus.rsp_rdata, bus.req_ready}, {1'b1, 8'h3C, 1'b0});
      end
    end
    @(posedge clk);
    #1 bus.rsp_ready = 1'b1;
    @(negedge clk);
    checks++;
    if (bus.req_ready !== 1'b1) begin
      errors++;
      $display("FAIL bp_ready_release: got %b required 1", bus.req_ready);
    end
    exp_q.push_back('{v: {2'b00, mem_m[3]}, cyc: cyc});
    @(posedge clk);
    #1 bus.req_valid = 1'b0;
    wait_rsp();
    for (int k = 0; k < 2; k++) begin
      e = exp_q.pop_front();
      checks++;
      if (got_q.size() == 0) begin
        errors++;
        $display("FAIL bp_rsp %0d: no response, required %h", k, e.v);
      end else begin
        g = got_q.pop_front();
        if (g.v !== e.v) begin
          errors++;
          $display("FAIL bp_rsp %0d: got %h required %h", k, g.v, e.v);
        end
        if (k == 0) g0 = g;
        else begin
          checks++;
          if (g.cyc - g0.cyc !== 1) begin
            errors++;
            $display("FAIL bp_back_to_back: got gap %0d required 1", g.cyc - g0.cyc);
          end
        end
      end
    end
  endtask

  task automatic test_clear_write();
    rsp_t e, g;
    clear = 1'b1;
    send(1'b1, 8'd5, 8'h77);
    clear = 1'b0;
    zero_model();
    checks++;
    if (busy !== 1'b1) begin
      errors++;
      $display("FAIL clear_start: got busy %b required 1", busy);
    end
    for (int i = 1; i <= 16; i++) begin
      @(posedge clk);
      #1;
      checks++;
      if ({busy, bus.req_ready} !== {i < 16, i == 16}) begin
        errors++;
        $display("FAIL clear_sweep edge %0d: got busy/ready %b required %b",
                 i, {busy, bus.req_ready}, {i < 16, i == 16});
      end
    end
    send(1'b0, 8'd5, 8'h00);
    send(1'b0, 8'd3, 8'h00);
    wait_rsp();
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      checks++;
      if (got_q.size() == 0) begin
        errors++;
        $display("FAIL clear_write: no response, required %h", e.v);
      end else begin
        g = got_q.pop_front();
        if (g.v !== e.v) begin
          errors++;
          $display("FAIL clear_write: got %h required %h", g.v, e.v);
        end
      end
    end
  endtask

  task automatic test_reset_mid_sweep();
    rsp_t e, g;
    send(1'b1, 8'd12, 8'h11);
    send(1'b1, 8'd0, 8'h42);
    wait_rsp();
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      if (got_q.size() > 0) g = got_q.pop_front();
    end
    bus.rsp_ready = 1'b0;
    clear = 1'b1;
    send(1'b0, 8'd0, 8'h00);
    clear = 1'b0;
    repeat (7) begin
      @(posedge clk);
      #1;
    end
    checks++;
    if ({busy, bus.rsp_valid, bus.rsp_rdata} !== {2'b11, 8'h42}) begin
      errors++;
      $display("FAIL pending_across_sweep: got busy/valid/rdata %b required %b",
               {busy, bus.rsp_valid, bus.rsp_rdata}, {2'b11, 8'h42});
    end
    e = exp_q.pop_back();
    rst_n = 1'b0;
    #1;
    checks++;
    if ({busy, bus.req_ready, bus.rsp_valid, bus.rsp_we, bus.rsp_err, bus.rsp_rdata} !== 13'b1_0000_0000_0000) begin
      errors++;
      $display("FAIL midsweep_reset: got %b required %b",
               {busy, bus.req_ready, bus.rsp_valid, bus.rsp_we, bus.rsp_err, bus.rsp_rdata}, 13'b1_0000_0000_0000);
    end
    bus.rsp_ready = 1'b1;
    zero_model();
    @(posedge clk);
    #1 rst_n = 1'b1;
    for (int i = 1; i <= 16; i++) begin
      @(posedge clk);
      #1;
      checks++;
      if ({busy, bus.req_ready} !== {i < 16, i == 16}) begin
        errors++;
        $display("FAIL midsweep_resweep edge %0d: got busy/ready %b required %b",
                 i, {busy, bus.req_ready}, {i < 16, i == 16});
      end
    end
    send(1'b0, 8'd12, 8'h00);
    send(1'b0, 8'd0, 8'h00);
    wait_rsp();
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      checks++;
      if (got_q.size() == 0) begin
        errors++;
        $display("FAIL midsweep_readback: no response, required %h", e.v);
      end else begin
        g = got_q.pop_front();
        if (g.v !== e.v) begin
          errors++;
          $display("FAIL midsweep_readback: got %h required %h", g.v, e.v);
        end
      end
    end
  endtask

  initial begin
    bus.req_valid = 1'b0;
    bus.req_we    = 1'b0;
    bus.req_addr  = 8'h00;
    bus.req_wdata = 8'h00;
    bus.rsp_ready = 1'b1;
    test_reset();
    test_write_read();
    test_range();
    test_backpressure();
    test_clear_write();
    test_reset_mid_sweep();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/data_mem_ctrl.md
# data_mem_ctrl

Parametrised single-port data memory with a valid/ready request/response handshake, a registered read, out-of-range address detection and a hardware clear sweep. It replaces the fixed 8-bit × 16 combinational-read data memory in the datapath. After every reset it zeroes its whole contents, so no location ever reads as undefined. It sits between the CPU memory stage (or a bus adapter) and the storage array.

## Interface
- DATA_W, 8, data word width in bits
- ADDR_W, 8, request address width in bits
- DEPTH, 16, number of words; must satisfy 2 ≤ DEPTH ≤ 2**ADDR_W
- clk  in  1  clock; all state changes on the rising edge
- rst_n  in  1  reset, asynchronous, active-low
- req_valid  in  1  request present
- req_ready  out  1  block can accept a request this cycle
- req_we  in  1  1 = write, 0 = read
- req_addr  in  ADDR_W  word address
- req_wdata  in  DATA_W  write data
- rsp_valid  out  1  response present
- rsp_ready  in  1  consumer takes the response this cycle
- rsp_we  out  1  echo of req_we for the request being answered
- rsp_rdata  out  DATA_W  read data; 0 for writes and errors
- rsp_err  out  1  request address was ≥ DEPTH
- clear  in  1  one-cycle pulse that starts a zeroing sweep
- busy  out  1  sweep in progress

## Operation
- States: CLEAR, IDLE. Async reset forces CLEAR with sweep pointer 0.
- Outputs while rst_n = 0: req_ready 0, busy 1, rsp_valid 0, rsp_we 0, rsp_rdata 0, rsp_err 0.
- CLEAR:
  - On each cycle, write 0 to mem[ptr] and increment ptr.
  - After the edge that writes DEPTH-1, go to IDLE and reset ptr to 0.
  - busy = 1 and req_ready = 0 throughout.
  - clear is ignored; the sweep is not restarted.
- IDLE:
  - busy = 0.
  - clear = 1 moves to CLEAR on the next edge.
  - A request accepted in that same cycle completes normally. A write from that request lands before the sweep and is then zeroed.
- req_ready = (state == IDLE) && (!rsp_valid || rsp_ready). It does not depend on req_valid or clear.
- Accept condition: req_valid && req_ready at a rising edge.
- Accepted write, addr < DEPTH: mem[addr] is updated at that edge. The response is rsp_we 1, rsp_rdata 0, rsp_err 0.
- Accepted read, addr < DEPTH: rsp_rdata = mem[addr] as held before that edge. rsp_we 0, rsp_err 0.
- Accepted request with addr ≥ DEPTH: no memory access. rsp_err 1, rsp_rdata 0, rsp_we echoes req_we.
- Only the low clog2(DEPTH) address bits index the array, and only after the range check passes.
- Response register:
  - Loaded at the accept edge.
  - Held stable while rsp_valid && !rsp_ready.
  - Cleared (rsp_valid 0) at an edge with rsp_ready && no new accept.
  - Simultaneous rsp_ready and a new accept: the new response replaces the old with no bubble.
  - A pending response stays valid across a CLEAR sweep.

## Timing
- Reset release: busy stays 1 for exactly DEPTH rising edges. req_ready rises after the DEPTH-th edge.
- clear in IDLE: busy = 1 from the next edge for DEPTH cycles.
- Latency is one cycle. Accept at edge N gives rsp_valid = 1 after edge N.
- Throughput is one request per cycle while rsp_ready is held high.
- Read-after-write to the same address on consecutive accepts returns the new data.
- rst_n asserted mid-sweep or mid-transaction drops any pending response. The sweep then restarts from entry 0.

## Structure
- Package data_mem_pkg:
  - state enum (CLEAR, IDLE).
  - helper function computing the index width from DEPTH.
- Sub-module data_mem_array:
  - Storage only, DATA_W × DEPTH.
  - Synchronous write port, asynchronous read port, no reset.
  - The controller muxes sweep writes and request writes into it.
- The top level holds the FSM, sweep pointer, range check and response register.

## Test plan
- Reset then release: busy = 1 for 16 cycles, req_ready = 0, all outputs 0. Afterwards, reading addresses 0..15 returns 0 with rsp_err 0.
- Write 0xA5 to addr 3, then read addr 3 back-to-back: first response is rsp_we 1, rdata 0; second is rdata 0xA5, one cycle after its accept.
- Read addr 16 and addr 0xFF: rsp_err 1, rdata 0. A following read of addr 0 shows memory unchanged.
- Hold rsp_ready = 0 after a read of 0x3C: rsp_valid and rdata stay stable and req_ready = 0. Raising rsp_ready with a new request pending gives back-to-back responses.
- Write 0x77 to addr 5 in the same cycle as clear: busy for 16 cycles, then reading addr 5 returns 0.
- Assert rst_n = 0 during cycle 8 of a sweep: outputs return to reset values, and a full 16-cycle sweep follows release.
